// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers, reused by multi-digit counters and decoder stages.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..CLK_DIV-1 and flags the last one as tick.
module tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] pre;

  // tick is the combinational step condition; the top registers it.
  assign tick = en && !rst && !clr && (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_digit_counter.sv
// Single-digit up/down decade counter with prescaler, parallel load and carry/borrow pulse.
module bcd_digit_counter
  import bcd_pkg::*;
#(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       step,
  output logic       carry
);

  logic tick;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= BCD_MIN;
      step  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      digit <= bcd_clamp(load_val);
      step  <= 1'b0;
      carry <= 1'b0;
    end else begin
      step  <= tick;
      carry <= 1'b0;
      if (tick) begin
        if (up_dn) begin
          if (digit >= BCD_MAX) begin
            digit <= BCD_MIN;
            carry <= 1'b1;
          end else begin
            digit <= digit + 4'd1;
          end
        end else begin
          if (digit == BCD_MIN) begin
            digit <= BCD_MAX;
            carry <= 1'b1;
          end else begin
            digit <= digit - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench: CLK_DIV=4 and CLK_DIV=1 instances driven in lockstep against a cycle model.
module tb_bcd_digit_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] digit4, digit1;
  logic       step4, step1, carry4, carry1;

  always #5 clk = ~clk;

  bcd_digit_counter #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .digit(digit4), .step(step4), .carry(carry4)
  );

  bcd_digit_counter #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .digit(digit1), .step(step1), .carry(carry1)
  );

  typedef struct packed {
    logic [3:0] d;
    logic       s;
    logic       c;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass = 0;
  int step_cnt4, carry_cnt4, step_cnt1, carry_cnt1;

  int         m_pre[2];
  logic [3:0] m_dig[2];
  int         m_div[2] = '{4, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int k, input logic r, input logic ld, input logic [3:0] lv,
                                 input logic e, input logic u);
    exp_t x;
    x.s = 1'b0;
    x.c = 1'b0;
    if (r) begin
      m_pre[k] = 0;
      m_dig[k] = 4'd0;
    end else if (ld) begin
      m_dig[k] = (lv > 4'd9) ? 4'd9 : lv;
      m_pre[k] = 0;
    end else if (e) begin
      if (m_pre[k] == m_div[k] - 1) begin
        m_pre[k] = 0;
        x.s = 1'b1;
        if (u) begin
          if (m_dig[k] == 4'd9) begin m_dig[k] = 4'd0; x.c = 1'b1; end
          else m_dig[k] = m_dig[k] + 4'd1;
        end else begin
          if (m_dig[k] == 4'd0) begin m_dig[k] = 4'd9; x.c = 1'b1; end
          else m_dig[k] = m_dig[k] - 4'd1;
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
    x.d = m_dig[k];
    return x;
  endfunction

  task automatic cycle(input logic r, input logic ld, input logic [3:0] lv, input logic e, input logic u);
    exp_t x4, x1;
    rst = r; load = ld; load_val = lv; en = e; up_dn = u;
    q4.push_back(model(0, r, ld, lv, e, u));
    q1.push_back(model(1, r, ld, lv, e, u));
    @(posedge clk);
    #1;
    x4 = q4.pop_front();
    x1 = q1.pop_front();
    check("d4_digit", {28'd0, digit4}, {28'd0, x4.d});
    check("d4_step", {31'd0, step4}, {31'd0, x4.s});
    check("d4_carry", {31'd0, carry4}, {31'd0, x4.c});
    check("d1_digit", {28'd0, digit1}, {28'd0, x1.d});
    check("d1_step", {31'd0, step1}, {31'd0, x1.s});
    check("d1_carry", {31'd0, carry1}, {31'd0, x1.c});
    check("d4_inv", {31'd0, (digit4 <= 4'd9)}, 32'd1);
    check("d1_inv", {31'd0, (digit1 <= 4'd9)}, 32'd1);
    step_cnt4  += int'(step4);
    carry_cnt4 += int'(carry4);
    step_cnt1  += int'(step1);
    carry_cnt1 += int'(carry1);
  endtask

  task automatic run(input int n, input logic e, input logic u);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, e, u);
  endtask

  task automatic clear_counts();
    step_cnt4 = 0; carry_cnt4 = 0; step_cnt1 = 0; carry_cnt1 = 0;
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("rst_digit", {28'd0, digit4}, 32'd0);

    // Up count over 44 enabled cycles
    clear_counts();
    run(44, 1'b1, 1'b1);
    check("up_steps4", step_cnt4, 11);
    check("up_carries4", carry_cnt4, 1);
    check("up_steps1", step_cnt1, 44);
    check("up_carries1", carry_cnt1, 4);
    check("up_final4", {28'd0, digit4}, 32'd1);

    // Down from 0 wraps to 9 with borrow, then 8
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    check("dn_wrap_digit", {28'd0, digit4}, 32'd9);
    check("dn_wrap_carry", {31'd0, carry4}, 32'd1);
    run(4, 1'b1, 1'b0);
    check("dn_next_digit", {28'd0, digit4}, 32'd8);
    check("dn_next_carry", {31'd0, carry4}, 32'd0);

    // Load mid-count, then clamped load
    run(6, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    check("load7", {28'd0, digit4}, 32'd7);
    run(3, 1'b1, 1'b1);
    check("load7_hold", {28'd0, digit4}, 32'd7);
    run(1, 1'b1, 1'b1);
    check("load7_step", {28'd0, digit4}, 32'd8);
    cycle(1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
    check("load13_clamp", {28'd0, digit4}, 32'd9);
    cycle(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
    check("load15_clamp", {28'd0, digit4}, 32'd9);

    // Enable drop holds digit and prescale position
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    run(14, 1'b1, 1'b1);
    check("pause_pre_digit", {28'd0, digit4}, 32'd3);
    clear_counts();
    run(10, 1'b0, 1'b1);
    check("pause_digit", {28'd0, digit4}, 32'd3);
    check("pause_steps", step_cnt4, 0);
    run(1, 1'b1, 1'b1);
    check("resume_1", {28'd0, digit4}, 32'd3);
    run(1, 1'b1, 1'b1);
    check("resume_2", {28'd0, digit4}, 32'd4);

    // Direction change mid-prescale
    run(2, 1'b1, 1'b1);
    run(2, 1'b1, 1'b0);
    check("dir_change", {28'd0, digit4}, 32'd3);

    // rst beats load; reset mid-prescale restarts the full period
    cycle(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    check("rst_over_load", {28'd0, digit4}, 32'd0);
    run(7, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("rst_mid_digit", {28'd0, digit4}, 32'd0);
    check("rst_mid_step", {31'd0, step4}, 32'd0);
    run(3, 1'b1, 1'b1);
    check("rst_restart_hold", {28'd0, digit4}, 32'd0);
    run(1, 1'b1, 1'b1);
    check("rst_restart_step", {28'd0, digit4}, 32'd1);

    // Random tail
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
- Registered single-digit decade counter that produces the 4-bit BCD value driving the board's BCD-to-7-segment decoder.
- Contains a programmable prescaler, so the displayed digit steps at a human-visible rate from the board clock.
- Supports up/down counting, synchronous parallel load, and a one-cycle carry/borrow pulse for cascading further digits.

Parameters:
- CLK_DIV, 50000000: board clock cycles per count step. Legal range is 1 or more; 1 means step every enabled cycle.
- DIV_W, $clog2(CLK_DIV) (minimum 1): prescaler register width. Derived; never overridden.

Ports:
- clk  input  1  board clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable. Low freezes both the prescaler and the digit.
- up_dn  input  1  count direction: 1 = up, 0 = down. Sampled on the step cycle.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4  BCD value for load. Values 10–15 are clamped to 9.
- digit  output  4  current BCD digit, 0–9, registered. Feeds the segment decoder input.
- step  output  1  one-cycle pulse marking each prescaler rollover. Registered.
- carry  output  1  one-cycle pulse on a 9→0 (up) or 0→9 (down) wrap. Registered.

Behaviour:
- Reset (rst=1 at an edge):
  - digit=0, step=0, carry=0, prescaler=0.
  - rst has priority over all other inputs.
  - A reset mid-count abandons any partial prescale.
- Priority per edge: rst > load > counting.
- Load (load=1, rst=0):
  - digit ← min(load_val, 9); prescaler ← 0; step=0; carry=0.
  - The en value is ignored on a load cycle.
- Prescaler (en=1, no load):
  - pre counts 0..CLK_DIV-1.
  - When pre == CLK_DIV-1, the internal step condition is true and pre ← 0 on the same edge.
  - Otherwise pre ← pre+1.
- Digit update, on an edge where the step condition is true:
  - Up, digit<9: digit+1.
  - Up, digit==9: digit ← 0 and carry ← 1.
  - Down, digit>0: digit-1.
  - Down, digit==0: digit ← 9 and carry ← 1.
- Pulse timing:
  - step and carry are 1 for exactly the cycle after the updating edge, coincident with the new digit value.
  - Otherwise both are 0.
- Latency:
  - After reset or load, the first digit change happens CLK_DIV enabled cycles later.
  - Digit, step and carry change together; there is no combinational path from any input to any output.
- en=0:
  - pre and digit hold.
  - step=0 and carry=0 on the next edge.
  - Re-asserting en resumes from the held pre value; no step is lost or duplicated.
- Direction change mid-prescale takes effect at the next step. It does not reset pre.
- CLK_DIV=1: step condition true every enabled cycle; pre stays 0.
- Invariant: digit is never 10–15 at any edge.

Decomposition:
- Shared package bcd_pkg:
  - localparams BCD_MAX=4'd9 and BCD_MIN=4'd0.
  - Clamp function bcd_clamp(4-bit) returning min(x, 9).
  - The package is reused by later multi-digit counters and decoder stages.
- One sub-module: tick_gen.
  - Parameter CLK_DIV.
  - Ports: clk, rst, en, clr, tick.
  - Implements the prescaler; clr is driven by load.
  - bcd_digit_counter instantiates it and registers its tick as step.

Test Plan (CLK_DIV=4 unless stated):
1. Reset, then en=1, up_dn=1 for 44 cycles → digit goes 0,1,…,9,0; changes occur every 4 cycles; carry pulses once at the 9→0 wrap; step pulses 11 times.
2. Reset, en=1, up_dn=0 → first step yields digit=9 with carry=1 for one cycle; the next step yields 8 with carry=0.
3. Mid-count, pulse load with load_val=4'd7 → digit=7 next cycle; the next change comes 4 enabled cycles later. Then load_val=4'd13 → digit=9.
4. Count up to digit=3, pre=2; drop en for 10 cycles → digit stays 3, step=0 throughout. Re-enable → digit=4 after exactly 2 cycles.
5. Assert load and rst on the same edge with load_val=5 → digit=0. Then assert rst while pre=3 with en=1 → digit=0, step=0, carry=0, and the full 4-cycle prescale restarts.
6. CLK_DIV=1, en=1, up_dn=1 from reset → digit increments every cycle and carry pulses every 10th cycle. The invariant digit≤9 is checked on every cycle of all tests.
